// File: rtl/tdm_demux1_4.sv
// Receive-side 1:4 TDM deframer.
// Tracks the slot index of a 1-bit serial stream and collects one bit per slot.
// The four held outputs Y update together, and only when a full frame is complete.
module tdm_demux1_4 #(
    parameter bit          REQUIRE_SYNC = 1'b1,
    parameter int unsigned TIMEOUT      = 255,
    parameter int unsigned CNT_W        = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din,
    input  logic             din_valid,
    input  logic             frame_sync,
    output logic [3:0]       Y,
    output logic [1:0]       slot,
    output logic             locked,
    output logic             frame_done,
    output logic             sync_err,
    output logic [CNT_W-1:0] frame_cnt
);

    localparam int unsigned TMR_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam int unsigned TMR_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [2:0]         shadow;
    logic [2:0]         shadow_nxt;
    logic [TMR_W-1:0]   timer;
    logic [TMR_W-1:0]   timer_nxt;
    logic [3:0]         y_nxt;
    logic [1:0]         slot_nxt;
    logic               done_nxt;
    logic               err_nxt;
    logic [CNT_W-1:0]   cnt_nxt;

    // State and output registers; reset clears any partial frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= UNLOCKED;
            shadow     <= 3'b000;
            timer      <= '0;
            Y          <= 4'b0000;
            slot       <= 2'd0;
            locked     <= 1'b0;
            frame_done <= 1'b0;
            sync_err   <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            state      <= state_nxt;
            shadow     <= shadow_nxt;
            timer      <= timer_nxt;
            Y          <= y_nxt;
            slot       <= slot_nxt;
            locked     <= (state_nxt == LOCKED);
            frame_done <= done_nxt;
            sync_err   <= err_nxt;
            frame_cnt  <= cnt_nxt;
        end
    end

    // Next-state: lock acquisition, slot tracking, frame completion and timeout.
    always_comb begin
        state_nxt  = state;
        shadow_nxt = shadow;
        timer_nxt  = timer;
        y_nxt      = Y;
        slot_nxt   = slot;
        done_nxt   = 1'b0;
        err_nxt    = 1'b0;
        cnt_nxt    = frame_cnt;

        case (state)
            UNLOCKED: begin
                timer_nxt = '0;
                if (din_valid && frame_sync) begin
                    shadow_nxt[0] = din;
                    slot_nxt      = 2'd1;
                    state_nxt     = LOCKED;
                end
            end

            LOCKED: begin
                if (din_valid) begin
                    timer_nxt = '0;
                    if (frame_sync && (slot != 2'd0)) begin
                        // Sync arrived early: drop the partial frame and restart at slot 1.
                        err_nxt       = 1'b1;
                        shadow_nxt[0] = din;
                        slot_nxt      = 2'd1;
                    end else if ((slot == 2'd0) && !frame_sync && REQUIRE_SYNC) begin
                        // Missing sync on a frame boundary means alignment is lost.
                        err_nxt   = 1'b1;
                        state_nxt = UNLOCKED;
                        slot_nxt  = 2'd0;
                    end else if (slot != 2'd3) begin
                        shadow_nxt[slot] = din;
                        slot_nxt         = slot + 2'd1;
                    end else begin
                        y_nxt    = {din, shadow};
                        done_nxt = 1'b1;
                        cnt_nxt  = frame_cnt + CNT_W'(1);
                        slot_nxt = 2'd0;
                    end
                end else if (slot == 2'd0) begin
                    timer_nxt = '0;
                end else if (TIMEOUT != 0) begin
                    // Mid-frame stall watchdog.
                    if (timer == TMR_W'(TMR_LAST)) begin
                        err_nxt   = 1'b1;
                        state_nxt = UNLOCKED;
                        slot_nxt  = 2'd0;
                        timer_nxt = '0;
                    end else begin
                        timer_nxt = timer + TMR_W'(1);
                    end
                end
            end

            default: begin
                state_nxt = UNLOCKED;
            end
        endcase
    end

endmodule
